mem1_req_queue: RTL and testbench

- Parametrised successor of the memory1 dcache-request path. Sits between memory1 address translation and the dcache.
- Buffers up to DEPTH translated load/store requests in program order and aligns store data and byte strobes for DATA_W-bit lines.
- Issues cached loads speculatively. Holds stores and uncached loads until the commit stage marks them non-speculative.
- On flush, discards speculative entries and keeps committed stores.

---
 rtl/cpu_defs.sv | 19 +
 rtl/mem_store_align.sv | 25 ++
 rtl/mem1_req_queue.sv | 106 ++++++++++
 tb/tb_mem1_req_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared memory-pipeline types for the memory1 request path and dcache.
package cpu_defs;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_IDX_W  = 32;
  typedef enum logic [1:0] {BT_BYTE = 2'd0, BT_HALF = 2'd1, BT_WORD = 2'd2, BT_DWORD = 2'd3} byte_type_t;
  typedef enum logic [1:0] {DC_OP_NONE = 2'd0, DC_OP_LOAD = 2'd1, DC_OP_STORE = 2'd2} dc_op_t;
  // Sized for the widest dcache line; narrower instances use the low bits.
  typedef struct packed {
    logic                    is_store;
    byte_type_t              byte_type;
    logic [MAX_IDX_W-1:0]    idx;
    logic [31:0]             pa;
    logic                    cached;
    logic [MAX_DATA_W-1:0]   wdata;
    logic [MAX_DATA_W/8-1:0] wstrb;
    logic                    needs_cmt;
    logic                    cmt;
  } mem_req_entry_t;
endpackage

// File: rtl/mem_store_align.sv
// mem_store_align: replicates store data across the line and builds byte strobes and the misalignment flag.
module mem_store_align import cpu_defs::*; #(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  byte_type_t        byte_type,
  input  logic [OW-1:0]     offset,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] adata,
  output logic [NB-1:0]     strb,
  output logic              ale
);
  logic [3:0]  bytes;
  logic [15:0] size_mask;
  always_comb begin
    bytes     = 4'd1 << byte_type;
    size_mask = (16'd1 << bytes) - 16'd1;
    adata     = byte_type == BT_BYTE ? {NB{data[7:0]}} :
                byte_type == BT_HALF ? {(NB/2){data[15:0]}} :
                byte_type == BT_WORD ? {(NB/4){data[31:0]}} : data;
    strb      = NB'(size_mask << offset);
    ale       = (|(offset & OW'(bytes - 4'd1))) | (bytes > 4'(NB));
  end
endmodule

// File: rtl/mem1_req_queue.sv
// mem1_req_queue: in-order translated load/store queue feeding the dcache, holding stores and uncached loads until commit.
module mem1_req_queue import cpu_defs::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_rdy,
  input  logic                       in_is_store,
  input  logic [1:0]                 in_byte_type,
  input  logic [31:0]                in_va,
  input  logic [31:0]                in_pa,
  input  logic                       in_is_cached,
  input  logic [DATA_W-1:0]          in_wdata,
  output logic                       in_ale,
  input  logic                       commit,
  output logic                       dc_valid,
  input  logic                       dc_rdy,
  output logic                       dc_is_store,
  output logic [1:0]                 dc_byte_type,
  output logic [IDX_W-1:0]           dc_idx,
  output logic [31:0]                dc_pa,
  output logic                       dc_is_cached,
  output logic [DATA_W-1:0]          dc_wdata,
  output logic [DATA_W/8-1:0]        dc_wstrb,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(DEPTH + 1);
  mem_req_entry_t    mem [DEPTH];
  mem_req_entry_t    h;
  logic [AW:0]       head, tail, ccnt, occ, fnd, ccnt_c, ccnt_n, head_n, tail_n;
  logic [AW-1:0]     rel;
  logic [DEPTH-1:0]  mark;
  logic [DATA_W-1:0] adata;
  logic [NB-1:0]     astrb;
  logic              full, enq, pop, hit;
  mem_store_align #(.DATA_W(DATA_W)) u_align (
    .byte_type(byte_type_t'(in_byte_type)),
    .offset(in_pa[OW-1:0]),
    .data(in_wdata),
    .adata(adata),
    .strb(astrb),
    .ale(in_ale)
  );
  assign h            = mem[head[AW-1:0]];
  assign occ          = tail - head;
  assign count        = CW'(occ);
  assign empty        = head == tail;
  assign full         = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
  assign in_rdy       = ~full;
  assign enq          = in_valid & in_rdy & ~in_ale & ~flush;
  assign dc_valid     = ~empty & (~h.needs_cmt | h.cmt) & ~(flush & ~h.cmt);
  assign pop          = dc_valid & dc_rdy;
  assign dc_is_store  = h.is_store;
  assign dc_byte_type = h.byte_type;
  assign dc_idx       = IDX_W'(h.idx);
  assign dc_pa        = h.pa;
  assign dc_is_cached = h.cached;
  assign dc_wdata     = DATA_W'(h.wdata);
  assign dc_wstrb     = NB'(h.wstrb);
  // A commit also marks older cached loads so the committed set stays a prefix from head.
  always_comb begin
    hit  = 1'b0;
    fnd  = '0;
    mark = '0;
    rel  = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!hit && (AW+1)'(i) >= ccnt && (AW+1)'(i) < occ && mem[head[AW-1:0] + AW'(i)].needs_cmt) begin
        hit = 1'b1;
        fnd = (AW+1)'(i);
      end
    for (int j = 0; j < DEPTH; j++) begin
      rel     = AW'(j) - head[AW-1:0];
      mark[j] = commit & hit & ({1'b0, rel} >= ccnt) & ({1'b0, rel} <= fnd);
    end
    ccnt_c = (commit & hit) ? fnd + (AW+1)'(1) : ccnt;
    ccnt_n = ccnt_c - (AW+1)'(pop && ccnt_c != '0);
    head_n = head + (AW+1)'(pop);
    tail_n = flush ? head_n + ccnt_n : tail + (AW+1)'(enq);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      ccnt <= '0;
    end else begin
      head <= head_n;
      tail <= tail_n;
      ccnt <= ccnt_n;
    end
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++)
      if (mark[j]) mem[j].cmt <= 1'b1;
    if (enq)
      mem[tail[AW-1:0]] <= '{is_store: in_is_store, byte_type: byte_type_t'(in_byte_type), idx: MAX_IDX_W'(in_va),
                             pa: in_pa, cached: in_is_cached, wdata: MAX_DATA_W'(adata),
                             wstrb: (MAX_DATA_W/8)'(astrb), needs_cmt: in_is_store | ~in_is_cached, cmt: 1'b0};
  end
endmodule

// File: tb/tb_mem1_req_queue.sv
// tb_mem1_req_queue: directed checks of the request queue at DATA_W=32 and an alignment vector table at DATA_W=64.
module tb_mem1_req_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic        flush = 0, in_valid = 0, in_is_store = 0, in_is_cached = 0, commit = 0, dc_rdy = 0;
  logic [1:0]  in_byte_type = 0;
  logic [31:0] in_va = 0, in_pa = 0, in_wdata = 0;
  logic        in_rdy, in_ale, dc_valid, dc_is_store, dc_is_cached, empty;
  logic [1:0]  dc_byte_type;
  logic [11:0] dc_idx;
  logic [31:0] dc_pa, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic [2:0]  count;
  logic        b_flush = 0, b_in_valid = 0, b_in_is_store = 0, b_in_is_cached = 0, b_commit = 0, b_dc_rdy = 0;
  logic [1:0]  b_in_byte_type = 0;
  logic [31:0] b_in_va = 0, b_in_pa = 0;
  logic [63:0] b_in_wdata = 0;
  logic        b_in_rdy, b_in_ale, b_dc_valid, b_dc_is_store, b_dc_is_cached, b_empty;
  logic [1:0]  b_dc_byte_type;
  logic [11:0] b_dc_idx;
  logic [31:0] b_dc_pa;
  logic [63:0] b_dc_wdata;
  logic [7:0]  b_dc_wstrb;
  logic [2:0]  b_count;
  mem1_req_queue #(.DATA_W(32), .DEPTH(4), .IDX_W(12)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_rdy(in_rdy),
    .in_is_store(in_is_store), .in_byte_type(in_byte_type), .in_va(in_va), .in_pa(in_pa),
    .in_is_cached(in_is_cached), .in_wdata(in_wdata), .in_ale(in_ale), .commit(commit),
    .dc_valid(dc_valid), .dc_rdy(dc_rdy), .dc_is_store(dc_is_store), .dc_byte_type(dc_byte_type),
    .dc_idx(dc_idx), .dc_pa(dc_pa), .dc_is_cached(dc_is_cached), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .count(count), .empty(empty)
  );
  mem1_req_queue #(.DATA_W(64), .DEPTH(4), .IDX_W(12)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_rdy(b_in_rdy),
    .in_is_store(b_in_is_store), .in_byte_type(b_in_byte_type), .in_va(b_in_va), .in_pa(b_in_pa),
    .in_is_cached(b_in_is_cached), .in_wdata(b_in_wdata), .in_ale(b_in_ale), .commit(b_commit),
    .dc_valid(b_dc_valid), .dc_rdy(b_dc_rdy), .dc_is_store(b_dc_is_store), .dc_byte_type(b_dc_byte_type),
    .dc_idx(b_dc_idx), .dc_pa(b_dc_pa), .dc_is_cached(b_dc_is_cached), .dc_wdata(b_dc_wdata),
    .dc_wstrb(b_dc_wstrb), .count(b_count), .empty(b_empty)
  );
  typedef struct {
    logic [1:0]  bt;
    logic [31:0] pa;
    logic [63:0] d;
    logic        ale;
    logic [63:0] xd;
    logic [7:0]  xs;
  } vec_t;
  vec_t v [8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic enq(input logic st, input logic cached, input logic [1:0] bt, input logic [31:0] pa, input logic [31:0] d);
    in_valid = 1; in_is_store = st; in_is_cached = cached; in_byte_type = bt;
    in_va = pa; in_pa = pa; in_wdata = d;
    tick();
    in_valid = 0;
  endtask
  initial begin
    v[0] = '{2'd0, 32'h2005, 64'hAB, 1'b0, 64'hABABABABABABABAB, 8'b0010_0000};
    v[1] = '{2'd1, 32'h2003, 64'h1234, 1'b1, 64'h0, 8'h0};
    v[2] = '{2'd1, 32'h2006, 64'h1234, 1'b0, 64'h1234123412341234, 8'b1100_0000};
    v[3] = '{2'd2, 32'h2004, 64'hDEADBEEF, 1'b0, 64'hDEADBEEFDEADBEEF, 8'hF0};
    v[4] = '{2'd2, 32'h2002, 64'hDEADBEEF, 1'b1, 64'h0, 8'h0};
    v[5] = '{2'd3, 32'h2000, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF, 8'hFF};
    v[6] = '{2'd3, 32'h2004, 64'h0123456789ABCDEF, 1'b1, 64'h0, 8'h0};
    v[7] = '{2'd0, 32'h2000, 64'h5A, 1'b0, 64'h5A5A5A5A5A5A5A5A, 8'h01};
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_dc_valid", dc_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst64_empty", b_empty, 1);
    // Store waits for commit, then issues with full strobes.
    dc_rdy = 1;
    enq(1, 1, 2'd2, 32'h1004, 32'hDEADBEEF);
    chk("st_count", count, 1);
    chk("st_spec", dc_valid, 0);
    repeat (3) begin tick(); chk("st_hold", dc_valid, 0); end
    commit = 1; tick(); commit = 0;
    chk("st_valid", dc_valid, 1);
    chk("st_wdata", dc_wdata, 32'hDEADBEEF);
    chk("st_wstrb", dc_wstrb, 4'b1111);
    chk("st_pa", dc_pa, 32'h1004);
    chk("st_idx", dc_idx, 12'h004);
    chk("st_is_store", dc_is_store, 1);
    chk("st_bt", dc_byte_type, 2'd2);
    tick();
    chk("st_empty", empty, 1);
    // Cached load stalls on dcache busy.
    dc_rdy = 0;
    enq(0, 1, 2'd2, 32'h3008, 0);
    for (int k = 0; k < 5; k++) begin
      chk("ld_valid", dc_valid, 1);
      chk("ld_pa", dc_pa, 32'h3008);
      tick();
    end
    dc_rdy = 1;
    chk("ld_valid_rdy", dc_valid, 1);
    tick();
    chk("ld_empty", empty, 1);
    chk("ld_gone", dc_valid, 0);
    dc_rdy = 0;
    // Fill, commit one, flush.
    for (int k = 0; k < 4; k++) enq(1, 1, 2'd2, 32'h100 + 32'(4 * k), 32'(k));
    chk("full_count", count, 4);
    chk("full_rdy", in_rdy, 0);
    commit = 1; tick(); commit = 0;
    flush = 1; tick(); flush = 0;
    chk("fl_count", count, 1);
    chk("fl_valid", dc_valid, 1);
    chk("fl_pa", dc_pa, 32'h100);
    dc_rdy = 1; tick(); dc_rdy = 0;
    chk("fl_empty", empty, 1);
    for (int k = 0; k < 4; k++) enq(0, 1, 2'd2, 32'h200 + 32'(4 * k), 0);
    chk("wrap_count", count, 4);
    chk("wrap_rdy", in_rdy, 0);
    dc_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_valid", dc_valid, 1);
      chk("wrap_pa", dc_pa, 32'h200 + 32'(4 * k));
      tick();
    end
    chk("wrap_empty", empty, 1);
    dc_rdy = 0;
    // Flush, commit and enqueue together.
    enq(1, 1, 2'd2, 32'h400, 32'h11);
    enq(1, 1, 2'd2, 32'h404, 32'h22);
    commit = 1; tick(); commit = 0;
    flush = 1; commit = 1; in_valid = 1; in_is_store = 1; in_pa = 32'h408; in_va = 32'h408;
    tick();
    flush = 0; commit = 0; in_valid = 0;
    chk("fce_count", count, 2);
    dc_rdy = 1;
    chk("fce_v0", dc_valid, 1);
    chk("fce_pa0", dc_pa, 32'h400);
    tick();
    chk("fce_v1", dc_valid, 1);
    chk("fce_pa1", dc_pa, 32'h404);
    tick();
    chk("fce_empty", empty, 1);
    dc_rdy = 0;
    // Uncached load: survives flush only when committed in that cycle.
    enq(0, 0, 2'd2, 32'h500, 0);
    chk("uc_spec", dc_valid, 0);
    flush = 1; commit = 1; tick(); flush = 0; commit = 0;
    chk("uc_count", count, 1);
    chk("uc_valid", dc_valid, 1);
    chk("uc_cached", dc_is_cached, 0);
    dc_rdy = 1; tick(); dc_rdy = 0;
    chk("uc_empty", empty, 1);
    enq(0, 0, 2'd2, 32'h600, 0);
    chk("ucd_spec", dc_valid, 0);
    flush = 1; #1;
    chk("ucd_flush_valid", dc_valid, 0);
    tick(); flush = 0;
    chk("ucd_count", count, 0);
    chk("ucd_empty", empty, 1);
    repeat (2) begin tick(); chk("ucd_never", dc_valid, 0); end
    // DWORD is misaligned on a 32-bit line.
    in_valid = 1; in_is_store = 1; in_byte_type = 2'd3; in_pa = 32'h0; #1;
    chk("dw32_ale", in_ale, 1);
    tick(); in_valid = 0;
    chk("dw32_count", count, 0);
    // 64-bit alignment table.
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1; b_in_is_store = 1; b_in_is_cached = 1; b_in_byte_type = v[i].bt;
      b_in_pa = v[i].pa; b_in_va = v[i].pa; b_in_wdata = v[i].d; #1;
      chk($sformatf("v%0d_ale", i), b_in_ale, v[i].ale);
      tick(); b_in_valid = 0;
      chk($sformatf("v%0d_count", i), b_count, v[i].ale ? 3'd0 : 3'd1);
      if (!v[i].ale) begin
        b_commit = 1; tick(); b_commit = 0;
        chk($sformatf("v%0d_valid", i), b_dc_valid, 1);
        chk($sformatf("v%0d_wdata", i), b_dc_wdata, v[i].xd);
        chk($sformatf("v%0d_wstrb", i), b_dc_wstrb, v[i].xs);
        b_dc_rdy = 1; tick(); b_dc_rdy = 0;
      end
      chk($sformatf("v%0d_empty", i), b_empty, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
